// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter slice.
package ram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic       PORT_A     = 1'b0;
  localparam logic       PORT_B     = 1'b1;
  localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage

// File: rtl/ram_arbiter_if.sv
// Core-side memory ports: fetch port A (read-only) and data port B (read/write).
// master = core side, slave = arbiter side.
interface ram_arbiter_if;
  logic        a_req_valid;
  logic        a_req_ready;
  logic [31:0] a_addr;
  logic        a_rsp_valid;
  logic [31:0] a_rsp_data;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] b_addr;
  logic        b_we;
  logic [3:0]  b_wstrb;
  logic [31:0] b_wdata;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;

  modport master (
    output a_req_valid, a_addr, b_req_valid, b_addr, b_we, b_wstrb, b_wdata,
    input  a_req_ready, a_rsp_valid, a_rsp_data, b_req_ready, b_rsp_valid, b_rsp_data
  );

  modport slave (
    input  a_req_valid, a_addr, b_req_valid, b_addr, b_we, b_wstrb, b_wdata,
    output a_req_ready, a_rsp_valid, a_rsp_data, b_req_ready, b_rsp_valid, b_rsp_data
  );
endinterface

// File: rtl/ram_byte_merge.sv
// Byte-lane merge for sub-word stores: strobed bytes come from new_word,
// the rest keep old_word.
module ram_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strobe,
  output logic [31:0] merged
);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign merged[8*i +: 8] = strobe[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between the fetch
// port (A) and the data port (B). Responses come one cycle after acceptance.
// Optional feature macro RAM_ARB_RMW_EN: sub-word stores become a two-cycle
// read-modify-write; without it every B write is a full-word write.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus,
  output logic          ram_write_enable,
  output logic [31:0]   ram_addr,
  output logic [31:0]   ram_write_data,
  input  logic [31:0]   ram_read_data
);

  state_t state, next_state;
  logic   prio;
  logic   grant_a, grant_b;
  logic   full_wr, go_rmw;
  logic   addr_oob;

  // Grants only in IDLE; on contention prio picks the winner.
  always_comb begin
    grant_a = (state == IDLE) && bus.a_req_valid && (!bus.b_req_valid || prio == PORT_A);
    grant_b = (state == IDLE) && bus.b_req_valid && (!bus.a_req_valid || prio == PORT_B);
  end

  assign bus.a_req_ready = grant_a;
  assign bus.b_req_ready = grant_b;

`ifdef RAM_ARB_RMW_EN
  logic [31:0] merged;
  logic [29:0] rmw_addr;
  logic [31:0] rmw_data;

  assign full_wr = grant_b && bus.b_we && (bus.b_wstrb == WSTRB_FULL);
  assign go_rmw  = grant_b && bus.b_we && (bus.b_wstrb != 4'h0) && (bus.b_wstrb != WSTRB_FULL);

  ram_byte_merge u_merge (
    .old_word (ram_read_data),
    .new_word (bus.b_wdata),
    .strobe   (bus.b_wstrb),
    .merged   (merged)
  );

  // Latch the merged word and its address while the old word is on the read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_addr <= '0;
      rmw_data <= '0;
    end else if (go_rmw) begin
      rmw_addr <= bus.b_addr[31:2];
      rmw_data <= merged;
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^bus.b_wstrb;
  assign full_wr      = grant_b && bus.b_we;
  assign go_rmw       = 1'b0;
`endif

  // Out-of-range addresses go to the RAM unchanged; the flag is for observation only.
  assign addr_oob = {2'b00, ram_addr[31:2]} >= 32'(RAM_SIZE);

  logic unused_bits;
  assign unused_bits = ^{bus.a_addr[1:0], bus.b_addr[1:0], addr_oob};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: a partial store spends one extra cycle writing the merged word.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go_rmw) next_state = RMW_WR;
      RMW_WR:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM-side outputs: address of the granted port, or the latched RMW word.
  always_comb begin
    ram_write_enable = 1'b0;
    ram_addr         = '0;
    ram_write_data   = '0;
`ifdef RAM_ARB_RMW_EN
    if (state == RMW_WR) begin
      ram_write_enable = 1'b1;
      ram_addr         = {rmw_addr, 2'b00};
      ram_write_data   = rmw_data;
    end else
`endif
    if (grant_a) begin
      ram_addr = {bus.a_addr[31:2], 2'b00};
    end else if (grant_b) begin
      ram_addr         = {bus.b_addr[31:2], 2'b00};
      ram_write_enable = full_wr;
      ram_write_data   = bus.b_wdata;
    end
  end

  // Round-robin pointer flips to the other port after every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prio <= PORT_A;
    else if (grant_a) prio <= PORT_B;
    else if (grant_b) prio <= PORT_A;
  end

  // One-cycle response pulses; data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a_rsp_valid <= 1'b0;
      bus.a_rsp_data  <= '0;
      bus.b_rsp_valid <= 1'b0;
      bus.b_rsp_data  <= '0;
    end else begin
      bus.a_rsp_valid <= grant_a;
      if (grant_a) bus.a_rsp_data <= ram_read_data;
      bus.b_rsp_valid <= 1'b0;
      if (grant_b && !bus.b_we) begin
        bus.b_rsp_valid <= 1'b1;
        bus.b_rsp_data  <= ram_read_data;
      end else if ((grant_b && !go_rmw) || state == RMW_WR) begin
        bus.b_rsp_valid <= 1'b1;
        bus.b_rsp_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level reference model
// (grant rule, response queues with due cycles, reference memory image),
// directed scenarios followed by randomized traffic.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_write_enable;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;

  ram_arbiter_if bus ();

  ram_arbiter #(.RAM_SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .ram_write_enable (ram_write_enable),
    .ram_addr         (ram_addr),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a backdoor load port.
  logic [31:0] mem [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  assign ram_read_data = mem[ram_addr[6:2]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (ram_write_enable) mem[ram_addr[6:2]] <= ram_write_data;
  end

  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        aq[$], bq[$];
  logic [31:0] ref_mem [32];
  logic        m_prio, m_busy;
  int          m_rmw_word;
  logic [31:0] m_rmw_val;
  int          cyc;
  int          tests, fails;
  logic        last_a_ready, last_b_ready, last_we;
  logic [31:0] obs_a_d, obs_b_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.a_req_valid = 1'b0; bus.a_addr = '0;
    bus.b_req_valid = 1'b0; bus.b_addr = '0; bus.b_we = 1'b0;
    bus.b_wstrb = '0; bus.b_wdata = '0;
  endtask

  task automatic model_reset();
    m_prio = 1'b0; m_busy = 1'b0;
    aq.delete(); bq.delete();
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic av, input logic [31:0] aa, input logic bv, input logic bwe,
                      input logic [3:0] bs, input logic [31:0] ba, input logic [31:0] bd);
    logic ga, gb, ewe;
    logic [31:0] eaddr, edata;
    int wa, wb;
    rsp_t r;
    @(negedge clk);
    bus.a_req_valid = av; bus.a_addr = aa;
    bus.b_req_valid = bv; bus.b_addr = ba; bus.b_we = bwe; bus.b_wstrb = bs; bus.b_wdata = bd;
    #1;
    obs_a_d = bus.a_rsp_data;
    obs_b_d = bus.b_rsp_data;
    if (aq.size() > 0 && aq[0].due == cyc) begin
      r = aq.pop_front();
      check($sformatf("a_rsp_valid@%0d", cyc), 32'(bus.a_rsp_valid), 32'd1);
      check($sformatf("a_rsp_data@%0d", cyc), bus.a_rsp_data, r.data);
    end else check($sformatf("a_rsp_valid@%0d", cyc), 32'(bus.a_rsp_valid), 32'd0);
    if (bq.size() > 0 && bq[0].due == cyc) begin
      r = bq.pop_front();
      check($sformatf("b_rsp_valid@%0d", cyc), 32'(bus.b_rsp_valid), 32'd1);
      check($sformatf("b_rsp_data@%0d", cyc), bus.b_rsp_data, r.data);
    end else check($sformatf("b_rsp_valid@%0d", cyc), 32'(bus.b_rsp_valid), 32'd0);

    ga = !m_busy && av && (!bv || !m_prio);
    gb = !m_busy && bv && (!av || m_prio);
    check($sformatf("a_ready@%0d", cyc), 32'(bus.a_req_ready), 32'(ga));
    check($sformatf("b_ready@%0d", cyc), 32'(bus.b_req_ready), 32'(gb));

    wa = int'(aa[6:2]);
    wb = int'(ba[6:2]);
    ewe = 1'b0; eaddr = '0; edata = '0;
    if (m_busy) begin
      ewe = 1'b1; eaddr = 32'(m_rmw_word) << 2; edata = m_rmw_val;
    end else if (ga) begin
      eaddr = {aa[31:2], 2'b00};
    end else if (gb) begin
      eaddr = {ba[31:2], 2'b00};
`ifdef RAM_ARB_RMW_EN
      ewe = bwe && (bs == 4'hF);
`else
      ewe = bwe;
`endif
      edata = bd;
    end
    check($sformatf("ram_we@%0d", cyc), 32'(ram_write_enable), 32'(ewe));
    check($sformatf("ram_addr@%0d", cyc), ram_addr, eaddr);
    if (ewe) check($sformatf("ram_wdata@%0d", cyc), ram_write_data, edata);
    last_a_ready = bus.a_req_ready;
    last_b_ready = bus.b_req_ready;
    last_we      = ram_write_enable;

    if (m_busy) begin
      ref_mem[m_rmw_word] = m_rmw_val;
      bq.push_back('{cyc + 1, 32'd0});
      m_busy = 1'b0;
    end
    if (ga) begin
      aq.push_back('{cyc + 1, ref_mem[wa]});
      m_prio = 1'b1;
    end
    if (gb) begin
      m_prio = 1'b0;
      if (!bwe) bq.push_back('{cyc + 1, ref_mem[wb]});
      else begin
`ifdef RAM_ARB_RMW_EN
        if (bs == 4'hF) begin
          ref_mem[wb] = bd;
          bq.push_back('{cyc + 1, 32'd0});
        end else if (bs == 4'h0) begin
          bq.push_back('{cyc + 1, 32'd0});
        end else begin
          m_busy = 1'b1;
          m_rmw_word = wb;
          for (int i = 0; i < 4; i++)
            m_rmw_val[8*i +: 8] = bs[i] ? bd[8*i +: 8] : ref_mem[wb][8*i +: 8];
        end
`else
        ref_mem[wb] = bd;
        bq.push_back('{cyc + 1, 32'd0});
`endif
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  // Backdoor RAM load; only used with nothing pending.
  task automatic bd_write(input int idx, input logic [31:0] val);
    @(negedge clk);
    drive_idle();
    bd_we = 1'b1; bd_idx = 5'(idx); bd_data = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    check("rst_we", 32'(ram_write_enable), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_a_rsp_valid", 32'(bus.a_rsp_valid), 32'd0);
    check("rst_b_rsp_valid", 32'(bus.b_rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] s;
    tests = 0; fails = 0; cyc = 0;
    model_reset();
    drive_idle();

    // Preload RAM under reset.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 5'(i);
      bd_data = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    #1;
    check("reset_a_rsp_valid", 32'(bus.a_rsp_valid), 32'd0);
    check("reset_b_rsp_valid", 32'(bus.b_rsp_valid), 32'd0);
    check("reset_a_rsp_data", bus.a_rsp_data, 32'd0);
    check("reset_b_rsp_data", bus.b_rsp_data, 32'd0);
    check("reset_a_ready", 32'(bus.a_req_ready), 32'd0);
    check("reset_b_ready", 32'(bus.b_req_ready), 32'd0);
    check("reset_we", 32'(ram_write_enable), 32'd0);
    rst = 1'b0;

    idle();
    // A reads word 4.
    step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, '0, '0);
    check("a_read_ready", 32'(last_a_ready), 32'd1);
    idle();
    check("a_read_data", obs_a_d, 32'hDEADBEEF);

    // Contention right after reset alternates A, B, A, B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0, 4'h0, 32'(32 + i * 4), '0);
      check($sformatf("alt_a%0d", i), 32'(last_a_ready), 32'((i % 2) == 0));
      check($sformatf("alt_b%0d", i), 32'(last_b_ready), 32'((i % 2) == 1));
    end
    idle();

    // Full write then read-back.
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h08, 32'h11223344);
    check("full_wr_we", 32'(last_we), 32'd1);
    step(1'b1, 32'h08, 1'b0, 1'b0, 4'h0, '0, '0);
    idle();
    check("full_wr_readback", obs_a_d, 32'h11223344);

    // Sub-word store to word 2; A stalls behind it.
    bd_write(2, 32'hAABBCCDD);
    step(1'b0, '0, 1'b1, 1'b1, 4'b0001, 32'h08, 32'h000000EE);
`ifdef RAM_ARB_RMW_EN
    check("rmw_accept_we", 32'(last_we), 32'd0);
    step(1'b1, 32'h08, 1'b0, 1'b0, 4'h0, '0, '0);
    check("rmw_a_stalled", 32'(last_a_ready), 32'd0);
    check("rmw_wr_we", 32'(last_we), 32'd1);
    step(1'b1, 32'h08, 1'b0, 1'b0, 4'h0, '0, '0);
    check("rmw_a_granted", 32'(last_a_ready), 32'd1);
    idle();
    check("rmw_merged", obs_a_d, 32'hAABBCCEE);
    check("rmw_mem", mem[2], 32'hAABBCCEE);

    // Reset while in RMW_WR aborts the write and its response.
    bd_write(3, 32'h55667788);
    step(1'b0, '0, 1'b1, 1'b1, 4'b0010, 32'h0C, 32'h0000AA00);
    do_reset();
    #1;
    check("rmw_rst_no_rsp", 32'(bus.b_rsp_valid), 32'd0);
    check("rmw_rst_mem", mem[3], 32'h55667788);
    idle();
`else
    step(1'b1, 32'h08, 1'b0, 1'b0, 4'h0, '0, '0);
    check("noRmw_a_granted", 32'(last_a_ready), 32'd1);
    idle();
    check("noRmw_full_word", obs_a_d, 32'h000000EE);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = 4'($urandom_range(0, 15));
      endcase
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s,
           32'($urandom_range(0, 127)), $urandom);
    end
    repeat (3) idle();

    check("a_queue_drained", 32'(aq.size()), 32'd0);
    check("b_queue_drained", 32'(bq.size()), 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
